// File: rtl/multdiv_ctrl_if.sv
// Interface bundling the decode, multdiv-unit and writeback signals around multdiv_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding core's view.
interface multdiv_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              md_issue;
   logic              md_is_div;
   logic [4:0]        md_rd;
   logic              md_ready;
   logic              md_exception;
   logic [DATA_W-1:0] md_result;
   logic              ctrl_mult;
   logic              ctrl_div;
   logic              stall;
   logic              wb_en;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              busy;

   modport master (
      output md_issue, md_is_div, md_rd, md_ready, md_exception, md_result,
      input  ctrl_mult, ctrl_div, stall, wb_en, wb_rd, wb_data, busy
   );

   modport slave (
      input  md_issue, md_is_div, md_rd, md_ready, md_exception, md_result,
      output ctrl_mult, ctrl_div, stall, wb_en, wb_rd, wb_data, busy
   );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the multi-cycle mult/div unit for the single-cycle core.
// Stalls fetch while a mul/div is in flight, then owns the regfile write port for one cycle,
// redirecting the write to rstatus when the unit reports an exception.
// Optional feature: define MULTDIV_TIMEOUT_EN to force an exception completion when the unit
// has not answered within TIMEOUT_CYCLES busy cycles.
module multdiv_ctrl #(
   parameter int          DATA_W         = 32,
   parameter int          CNT_W          = 6,
   parameter int          TIMEOUT_CYCLES = 40,
   parameter logic [4:0]  RSTATUS_REG    = 5'd30,
   parameter int unsigned EXC_MUL_CODE   = 4,
   parameter int unsigned EXC_DIV_CODE   = 5
) (
   input logic           clock,
   input logic           reset_n,
   multdiv_ctrl_if.slave bus
);

   localparam logic [DATA_W-1:0] ExcMulData = DATA_W'(EXC_MUL_CODE);
   localparam logic [DATA_W-1:0] ExcDivData = DATA_W'(EXC_DIV_CODE);
`ifdef MULTDIV_TIMEOUT_EN
   localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      WB
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        rd_q, rd_d;
   logic              isDiv_q, isDiv_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              exc_q, exc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              ctrlMult;
   logic              ctrlDiv;
   logic              stall;
   logic              wbEn;
   logic [4:0]        wbRd;
   logic [DATA_W-1:0] wbData;

   // State and latched instruction/result registers; reset drops any in-flight operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rd_q     <= '0;
         isDiv_q  <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         isDiv_q  <= isDiv_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and control decode: stall is combinational in IDLE so the PC never moves past
   // the mul/div, START fires the one-cycle start pulse, BUSY waits for the unit, WB retires.
   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      isDiv_d  = isDiv_q;
      result_d = result_q;
      exc_d    = exc_q;
      cnt_d    = cnt_q;
      ctrlMult = 1'b0;
      ctrlDiv  = 1'b0;
      stall    = 1'b0;
      wbEn     = 1'b0;
      case (state_q)
         IDLE: begin
            stall = bus.md_issue;
            if (bus.md_issue) begin
               rd_d    = bus.md_rd;
               isDiv_d = bus.md_is_div;
               state_d = START;
            end
         end
         START: begin
            stall    = 1'b1;
            ctrlMult = ~isDiv_q;
            ctrlDiv  = isDiv_q;
            cnt_d    = '0;
            state_d  = BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.md_ready) begin
               result_d = bus.md_result;
               exc_d    = bus.md_exception;
               state_d  = WB;
            end
`ifdef MULTDIV_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               result_d = '0;
               exc_d    = 1'b1;
               state_d  = WB;
            end
`endif
         end
         WB: begin
            wbEn    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Writeback mux: an exception redirects the write to rstatus with a mul/div-specific code,
   // and the port reads as zero whenever this block is not writing.
   always_comb begin
      wbRd   = '0;
      wbData = '0;
      if (wbEn) begin
         if (exc_q) begin
            wbRd   = RSTATUS_REG;
            wbData = isDiv_q ? ExcDivData : ExcMulData;
         end else begin
            wbRd   = rd_q;
            wbData = result_q;
         end
      end
   end

   assign bus.ctrl_mult = ctrlMult;
   assign bus.ctrl_div  = ctrlDiv;
   assign bus.stall     = stall;
   assign bus.wb_en     = wbEn;
   assign bus.wb_rd     = wbRd;
   assign bus.wb_data   = wbData;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: directed and randomized mul/div transactions checked against a
// transaction-level model of timing and writeback values.
module tb_multdiv_ctrl;

   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 40;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   nChecks = 0;
   int   nFails  = 0;

   multdiv_ctrl_if #(.DATA_W(DATA_W)) bus ();

   multdiv_ctrl #(.DATA_W(DATA_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running core clock.
   always #5 clock = ~clock;

   // Hard stop in case something never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value with its expected value and record the outcome.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: register the instruction retires into.
   function automatic logic [4:0] modelRd(input bit exc, input logic [4:0] rd);
      return exc ? 5'd30 : rd;
   endfunction

   // Reference model: value the instruction retires with.
   function automatic logic [31:0] modelData(input bit exc, input bit isDiv, input logic [31:0] res);
      if (exc) return isDiv ? 32'd5 : 32'd4;
      return res;
   endfunction

   // One mul/div transaction starting in IDLE at posedge+1. lat = cycles after the start pulse
   // at which md_ready arrives; with giveReady=0 the unit never answers (timeout build).
   // Returns after sampling the writeback cycle, leaving md_issue asserted.
   task automatic applyStimulus(input string name, input bit isDiv, input logic [4:0] rd,
                                input int lat, input bit exc, input logic [31:0] res,
                                input bit giveReady, input bit startNoise);
      int         cyc = 0;
      int         pulses = 0;
      int         pulseCyc = -1;
      int         wrongKind = 0;
      int         stallCycles = 0;
      int         busyCycles = 0;
      int         leaks = 0;
      int         wbCyc = -1;
      int         expWbCyc;
      bit         expExc;
      logic [4:0] gotRd = '0;
      logic [31:0] gotData = '0;
      logic       gotStall = 1'b1;
      expExc   = exc || !giveReady;
      expWbCyc = giveReady ? lat + 2 : TIMEOUT + 2;
      bus.md_issue  = 1'b1;
      bus.md_is_div = isDiv;
      bus.md_rd     = rd;
      while (wbCyc < 0 && cyc < 200) begin
         bus.md_ready     = 1'b0;
         bus.md_exception = 1'($urandom_range(0, 1));
         bus.md_result    = $urandom();
         if (cyc == 1 && startNoise) bus.md_ready = 1'b1;
         if (giveReady && cyc == 1 + lat) begin
            bus.md_ready     = 1'b1;
            bus.md_exception = exc;
            bus.md_result    = res;
         end
         #1;
         if (cyc == 0) checkOutput({name, " idle busy"}, 32'(bus.busy), 32'd0);
         if (bus.ctrl_mult || bus.ctrl_div) begin
            pulses++;
            pulseCyc = cyc;
         end
         if ((bus.ctrl_mult && isDiv) || (bus.ctrl_div && !isDiv)) wrongKind++;
         stallCycles += int'(bus.stall);
         busyCycles  += int'(bus.busy);
         if (bus.wb_en) begin
            wbCyc    = cyc;
            gotRd    = bus.wb_rd;
            gotData  = bus.wb_data;
            gotStall = bus.stall;
         end else begin
            if (bus.wb_rd != '0 || bus.wb_data != '0) leaks++;
            @(posedge clock);
            #1;
            cyc++;
         end
      end
      bus.md_ready = 1'b0;
      checkOutput({name, " wb cycle"}, 32'(wbCyc), 32'(expWbCyc));
      checkOutput({name, " wb_rd"}, 32'(gotRd), 32'(modelRd(expExc, rd)));
      checkOutput({name, " wb_data"}, gotData, modelData(expExc, isDiv, res));
      checkOutput({name, " wb stall"}, 32'(gotStall), 32'd0);
      checkOutput({name, " start pulses"}, 32'(pulses), 32'd1);
      checkOutput({name, " pulse cycle"}, 32'(pulseCyc), 32'd1);
      checkOutput({name, " pulse kind errors"}, 32'(wrongKind), 32'd0);
      checkOutput({name, " stall cycles"}, 32'(stallCycles), 32'(expWbCyc));
      checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expWbCyc));
      checkOutput({name, " idle wb leaks"}, 32'(leaks), 32'd0);
   endtask

   // Advance out of the writeback cycle and idle one cycle with no instruction issued.
   task automatic idleAfter(input string name);
      @(posedge clock);
      #1;
      bus.md_issue = 1'b0;
      #1;
      checkOutput({name, " idle stall"}, 32'(bus.stall), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int wbSeen;
      int isDivR, excR, latR, noiseR;
      logic [4:0]  rdR;
      logic [31:0] resR;

      bus.md_issue     = 1'b0;
      bus.md_is_div    = 1'b0;
      bus.md_rd        = '0;
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
      bus.md_result    = '0;

      // Reset state.
      #12;
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset stall", 32'(bus.stall), 32'd0);
      checkOutput("reset wb_en", 32'(bus.wb_en), 32'd0);
      checkOutput("reset pulses", 32'({bus.ctrl_mult, bus.ctrl_div}), 32'd0);
      checkOutput("reset wb_data", bus.wb_data, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Directed: mul rd=7, ready 5 cycles after the start pulse.
      applyStimulus("mul", 1'b0, 5'd7, 5, 1'b0, 32'h0000_0030, 1'b1, 1'b0);
      idleAfter("mul");

      // Directed: divide by zero.
      applyStimulus("divzero", 1'b1, 5'd3, 3, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
      idleAfter("divzero");

      // Directed: mul overflow, result ignored.
      applyStimulus("mulovf", 1'b0, 5'd12, 1, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
      idleAfter("mulovf");

      // Directed: back-to-back mul rd=1 then div rd=2 with md_issue held across WB.
      applyStimulus("b2b first", 1'b0, 5'd1, 2, 1'b0, 32'h0000_0111, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      applyStimulus("b2b second", 1'b1, 5'd2, 4, 1'b0, 32'h0000_0222, 1'b1, 1'b0);
      idleAfter("b2b second");

      // Ready arriving in the last allowed busy cycle completes normally.
      applyStimulus("late ready", 1'b1, 5'd9, TIMEOUT, 1'b0, 32'hCAFE_0001, 1'b1, 1'b0);
      idleAfter("late ready");

      // Randomized transactions.
      for (int i = 0; i < 10; i++) begin
         isDivR = int'($urandom_range(0, 1));
         excR   = ($urandom_range(0, 3) == 0) ? 1 : 0;
         latR   = int'($urandom_range(1, 12));
         noiseR = int'($urandom_range(0, 1));
         rdR    = 5'($urandom());
         resR   = $urandom();
         applyStimulus($sformatf("rand%0d", i), 1'(isDivR), rdR, latR, 1'(excR), resR, 1'b1, 1'(noiseR));
         idleAfter($sformatf("rand%0d", i));
      end

      // Unit never answers.
`ifdef MULTDIV_TIMEOUT_EN
      applyStimulus("timeout", 1'b0, 5'd17, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      idleAfter("timeout");
`else
      bus.md_issue  = 1'b1;
      bus.md_is_div = 1'b0;
      bus.md_rd     = 5'd17;
      wbSeen        = 0;
      for (int c = 0; c < 102; c++) begin
         @(posedge clock);
         #1;
         wbSeen += int'(bus.wb_en);
      end
      checkOutput("no timeout busy", 32'(bus.busy), 32'd1);
      checkOutput("no timeout stall", 32'(bus.stall), 32'd1);
      checkOutput("no timeout wb_en", 32'(wbSeen), 32'd0);
      reset_n      = 1'b0;
      bus.md_issue = 1'b0;
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
`endif

      // Reset in the middle of BUSY drops the operation.
      bus.md_issue  = 1'b1;
      bus.md_is_div = 1'b1;
      bus.md_rd     = 5'd21;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
      end
      checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
      #2;
      reset_n          = 1'b0;
      bus.md_issue     = 1'b0;
      bus.md_ready     = 1'b1;
      bus.md_result    = 32'h5555_AAAA;
      #1;
      checkOutput("mid reset busy", 32'(bus.busy), 32'd0);
      checkOutput("mid reset stall", 32'(bus.stall), 32'd0);
      checkOutput("mid reset wb_en", 32'(bus.wb_en), 32'd0);
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      wbSeen  = 0;
      for (int c = 0; c < 10; c++) begin
         bus.md_ready = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         wbSeen += int'(bus.wb_en) + int'(bus.busy);
      end
      bus.md_ready = 1'b0;
      checkOutput("post reset activity", 32'(wbSeen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
